// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit (shift-add multiply, restoring divide) with HI/LO results.
// Define MULDIV_FAST_MUL_EN to compute MULT/MULTU with a single-cycle multiplier instead.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             annul,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero,
    output logic             stallreq
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state, state_nx;
    logic                 is_div_q;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic                 res_neg, dvd_neg;
    logic [2*WIDTH-1:0]   part, part_nx;
    logic [CW-1:0]        cnt;

    logic                 accept, a_neg, b_neg, dbz_in, last, load;
    logic [WIDTH-1:0]     ma_in, mb_in;
    logic [WIDTH:0]       rem_sh, diff;
    logic [WIDTH-1:0]     hi_nx, lo_nx;
    logic                 dbz_nx;
`ifndef MULDIV_FAST_MUL_EN
    logic [WIDTH:0]       add_sum;
`endif

    // Request decode and operand magnitudes
    always_comb begin
        accept = (state == IDLE) && start && !annul;
        a_neg  = !op[0] && opa[WIDTH-1];
        b_neg  = !op[0] && opb[WIDTH-1];
        ma_in  = a_neg ? -opa : opa;
        mb_in  = b_neg ? -opb : opb;
        dbz_in = op[1] && (opb == '0);
    end

    // part holds {partial remainder, dividend/quotient} for divide and
    // {accumulator, multiplier} for multiply; both shift one bit per cycle.
    always_comb begin
        rem_sh = part[2*WIDTH-1:WIDTH-1];
        diff   = rem_sh - {1'b0, mag_b};
        part_nx = part;
`ifdef MULDIV_FAST_MUL_EN
        last = !is_div_q || (cnt == CW'(WIDTH - 1));
`else
        last    = (cnt == CW'(WIDTH - 1));
        add_sum = {1'b0, part[2*WIDTH-1:WIDTH]} + {1'b0, (part[0] ? mag_a : '0)};
`endif
        if (is_div_q) begin
            if (diff[WIDTH])
                part_nx = {rem_sh[WIDTH-1:0], part[WIDTH-2:0], 1'b0};
            else
                part_nx = {diff[WIDTH-1:0], part[WIDTH-2:0], 1'b1};
        end else begin
`ifdef MULDIV_FAST_MUL_EN
            part_nx = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`else
            part_nx = {add_sum, part[WIDTH-1:1]};
`endif
        end
    end

    // Result staging with sign correction; divide-by-zero bypasses CALC
    always_comb begin
        hi_nx  = '0;
        lo_nx  = '0;
        dbz_nx = 1'b0;
        load   = 1'b0;
        if (state == IDLE) begin
            load   = accept && dbz_in;
            hi_nx  = opa;
            lo_nx  = '1;
            dbz_nx = 1'b1;
        end else if (state == CALC) begin
            load = !annul && last;
            if (is_div_q) begin
                lo_nx = res_neg ? -part_nx[WIDTH-1:0] : part_nx[WIDTH-1:0];
                hi_nx = dvd_neg ? -part_nx[2*WIDTH-1:WIDTH] : part_nx[2*WIDTH-1:WIDTH];
            end else begin
                {hi_nx, lo_nx} = res_neg ? -part_nx : part_nx;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = dbz_in ? DONE : CALC;
            CALC: begin
                if (annul)     state_nx = IDLE;
                else if (last) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        busy     = (state != IDLE);
        done     = (state == DONE) && !annul;
        stallreq = accept || (state == CALC);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            is_div_q    <= 1'b0;
            mag_a       <= '0;
            mag_b       <= '0;
            res_neg     <= 1'b0;
            dvd_neg     <= 1'b0;
            part        <= '0;
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            if (accept) begin
                is_div_q <= op[1];
                mag_a    <= ma_in;
                mag_b    <= mb_in;
                res_neg  <= a_neg ^ b_neg;
                dvd_neg  <= a_neg;
                part     <= op[1] ? {{WIDTH{1'b0}}, ma_in} : {{WIDTH{1'b0}}, mb_in};
                cnt      <= '0;
            end else if (state == CALC) begin
                part <= part_nx;
                cnt  <= cnt + CW'(1);
            end
            if (load) begin
                hi          <= hi_nx;
                lo          <= lo_nx;
                div_by_zero <= dbz_nx;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops
// compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst, start, annul, busy, done, div_by_zero, stallreq;
    logic [1:0]  op;
    logic [31:0] opa, opb, hi, lo;

    int checks = 0;
    int errors = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 33;
`endif

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
        .annul(annul), .busy(busy), .done(done), .hi(hi), .lo(lo),
        .div_by_zero(div_by_zero), .stallreq(stallreq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l, output logic z);
        longint      sa, sb;
        logic [63:0] p;
        z = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'd0: p = 64'(sa * sb);
            2'd1: p = {32'd0, a} * {32'd0, b};
            2'd2: p = (b == 0) ? 64'd0 : {32'(sa % sb), 32'(sa / sb)};
            default: p = (b == 0) ? 64'd0 : {32'({32'd0, a} % {32'd0, b}), 32'({32'd0, a} / {32'd0, b})};
        endcase
        {h, l} = p;
        if (o[1] && b == 0) begin
            h = a;
            l = '1;
            z = 1'b1;
        end
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] eh, el;
        logic        ez;
        int          lat, cyc, bad;
        model(o, a, b, eh, el, ez);
        lat = o[1] ? ((b == 0) ? 1 : 33) : MUL_LAT;
        @(negedge clk);
        start = 1'b1; op = o; opa = a; opb = b;
        #1 chk({tag, "_stall0"}, 64'(stallreq), 64'(1'b1));
        @(negedge clk);
        start = 1'b0; op = 2'($urandom); opa = $urandom; opb = $urandom;
        #1;
        cyc = 1;
        bad = 0;
        while (!done && cyc < 100) begin
            if (!stallreq || !busy) bad++;
            @(negedge clk);
            #1 cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'(lat));
        chk({tag, "_calc_stall_busy"}, 64'(bad), 64'(0));
        chk({tag, "_hi"}, 64'(hi), 64'(eh));
        chk({tag, "_lo"}, 64'(lo), 64'(el));
        chk({tag, "_dbz"}, 64'(div_by_zero), 64'(ez));
        chk({tag, "_stall_done"}, 64'(stallreq), 64'(1'b0));
        chk({tag, "_busy_done"}, 64'(busy), 64'(1'b1));
        @(negedge clk);
        #1 chk({tag, "_idle"}, 64'({busy, done}), 64'(2'b00));
    endtask

    function automatic logic [31:0] pick(input int allow_one);
        case ($urandom_range(0, 6))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h0;
            3: return allow_one != 0 ? 32'h1 : $urandom;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] eh, el;
        logic        ez;
        int          bad, dcount;

        rst = 1'b1; start = 1'b0; annul = 1'b0; op = '0; opa = '0; opb = '0;
        repeat (3) @(negedge clk);
        #1 chk("reset_outs", 64'({busy, done, hi, lo, div_by_zero, stallreq}), 64'(0));
        rst = 1'b0;

        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        chk("div_m7_2_lo_lit", 64'(lo), 64'(32'hFFFF_FFFD));
        chk("div_m7_2_hi_lit", 64'(hi), 64'(32'hFFFF_FFFF));
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        chk("multu_max_lit", 64'({hi, lo}), 64'hFFFF_FFFE_0000_0001);
        run_op(2'd0, 32'hFFFF_FFFE, 32'd3, "mult_m2_3");
        chk("mult_m2_3_lit", 64'({hi, lo}), 64'hFFFF_FFFF_FFFF_FFFA);
        run_op(2'd3, 32'h1234_5678, 32'd0, "divu_zero");
        chk("divu_zero_lit", 64'({div_by_zero, hi, lo}), {31'd0, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF});
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        chk("div_ovf_lit", 64'({div_by_zero, hi, lo}), 64'(32'h8000_0000));

        // Annul mid-CALC keeps previous results
        run_op(2'd2, 32'd68, 32'd9, "div_68_9");
        chk("div_68_9_lit", 64'({hi, lo}), {32'd5, 32'd7});
        @(negedge clk);
        start = 1'b1; op = 2'd3; opa = 32'd1000; opb = 32'd3;
        bad = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 10) annul = 1'b1;
            #1 if (done || !busy) bad++;
        end
        chk("annul_calc_run", 64'(bad), 64'(0));
        @(negedge clk);
        annul = 1'b0;
        #1 chk("annul_calc_idle", 64'({busy, done}), 64'(0));
        chk("annul_calc_keep", 64'({hi, lo}), {32'd5, 32'd7});
        run_op(2'd3, 32'd1000, 32'd3, "after_annul");

        // Annul during DONE suppresses the done pulse
        @(negedge clk);
        start = 1'b1; op = 2'd3; opa = 32'd44; opb = 32'd0;
        @(negedge clk);
        start = 1'b0; annul = 1'b1;
        #1 chk("annul_done_pulse", 64'(done), 64'(1'b0));
        @(negedge clk);
        annul = 1'b0;
        #1 chk("annul_done_idle", 64'(busy), 64'(1'b0));

        // Annul in IDLE rejects the request
        @(negedge clk);
        start = 1'b1; annul = 1'b1; op = 2'd1; opa = 32'd3; opb = 32'd4;
        #1 chk("annul_idle_stall", 64'(stallreq), 64'(1'b0));
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        #1 chk("annul_idle_busy", 64'(busy), 64'(1'b0));

        // Synchronous reset mid-divide clears everything
        run_op(2'd0, 32'h1234_5678, 32'h9ABC_DEF0, "pre_reset");
        @(negedge clk);
        start = 1'b1; op = 2'd2; opa = 32'd12345; opb = 32'd17;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1 chk("mid_reset_outs", 64'({busy, done, hi, lo, div_by_zero, stallreq}), 64'(0));

        // Starts during CALC and DONE are ignored
        model(2'd3, 32'hDEAD_BEEF, 32'd77, eh, el, ez);
        @(negedge clk);
        start = 1'b1; op = 2'd3; opa = 32'hDEAD_BEEF; opb = 32'd77;
        dcount = 0;
        for (int k = 1; k < 80; k++) begin
            @(negedge clk);
            start = (k == 5);
            if (k == 5) begin op = 2'd0; opa = 32'd9; opb = 32'd9; end
            #1;
            if (done) begin
                dcount++;
                chk("ignore_start_res", 64'({hi, lo}), {eh, el});
                start = 1'b1;
                op = 2'd1; opa = 32'd5; opb = 32'd6;
            end
        end
        chk("ignore_start_dones", 64'(dcount), 64'(1));
        chk("ignore_start_idle", 64'(busy), 64'(1'b0));

        repeat (40) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = pick(0);
            rb = pick(1);
            run_op(ro, ra, rb, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit for the EX stage. Accepts signed or unsigned MULT/MULTU/DIV/DIVU requests through a start/done handshake and produces a 2×WIDTH result as HI/LO halves. It raises a stall request while busy so the pipeline holds EX, and supports mid-operation annul and divide-by-zero detection. It replaces the separate fixed-width mul/div instances.

## Interface
- WIDTH, 32, operand width; results are WIDTH each for HI and LO; must be ≥4 and even.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request strobe; sampled only in IDLE.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- opa  in  WIDTH  multiplicand / dividend.
- opb  in  WIDTH  multiplier / divisor.
- annul  in  1  abort the current operation; has priority over start.
- busy  out  1  high in CALC and DONE.
- done  out  1  one-cycle pulse; hi/lo valid.
- hi  out  WIDTH  MULT: product[2W-1:W]; DIV: remainder.
- lo  out  WIDTH  MULT: product[W-1:0]; DIV: quotient.
- div_by_zero  out  1  valid with done; 1 if DIV/DIVU had opb==0.
- stallreq  out  1  combinational: (IDLE & start & ~annul) | CALC.

## Operation
- States: IDLE, CALC, DONE. The counter is $clog2(WIDTH)+1 bits wide.
- IDLE: on start & ~annul, latch op and operand magnitudes, latch the result sign and dividend sign, clear the partial result, set the counter to 0, and go to CALC.
- A DIV/DIVU request with opb==0 goes to DONE instead, with hi=opa, lo={WIDTH{1}}, div_by_zero=1.
- CALC, multiply: shift-add, one multiplier bit per cycle, producing a 2W-bit unsigned product.
- CALC, divide: restoring division, one quotient bit per cycle, using a (WIDTH+1)-bit partial remainder.
- CALC runs for WIDTH cycles. On the last cycle, apply sign correction and load hi/lo, then go to DONE.
- Signed correction for MULT: negate the 2W-bit product if sign(opa)^sign(opb).
- Signed correction for DIV: negate the quotient if the operand signs differ; the remainder takes the sign of the dividend.
- Signed overflow: most-negative / −1 gives lo=most-negative (wrapped) and hi=0, div_by_zero=0.
- DONE: assert done for one cycle, then go to IDLE.
- hi, lo and div_by_zero hold their values until the next done. They are written only on the transition into DONE.
- start while busy is ignored, including start during DONE; no queuing.
- annul in CALC or DONE: go to IDLE next cycle. done is not asserted (suppressed in DONE), and hi/lo/div_by_zero keep their previous values.
- annul in IDLE: the request is not accepted.
- Reset values: state IDLE; busy=0, done=0, hi=0, lo=0, div_by_zero=0, stallreq=0 (given start=0). Reset mid-operation discards all work.

## Timing
- Start accepted at cycle 0. CALC occupies cycles 1..WIDTH; done is high in cycle WIDTH+1, and hi/lo are valid from that cycle.
- Divide by zero: done in cycle 1.
- With MULDIV_FAST_MUL_EN, multiplies take CALC for 1 cycle, so done is in cycle 2.
- busy is high from cycle 1 through the done cycle inclusive.
- stallreq is high in cycle 0 (combinational) through the last CALC cycle, and low in the done cycle so EX advances with the result.
- The earliest next start is accepted in the cycle after done.

## Configuration
- MULDIV_FAST_MUL_EN defined: MULT/MULTU compute the full 2W-bit product with a single-cycle `*` in CALC, registered at the end of that cycle; total latency is 2. Division is unchanged.
- Not defined: multiplies use the iterative shift-add path with WIDTH-cycle latency, the same as division.

## Test plan
- DIV, opa=0xFFFFFFF9 (−7), opb=2 → done at cycle 33, lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_by_zero=0; stallreq high cycles 0–32.
- MULTU, 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. MULT, 0xFFFFFFFE × 3 → hi=0xFFFFFFFF, lo=0xFFFFFFFA. Cycle counts: 33 without the macro, 2 with it.
- DIVU, opa=0x12345678, opb=0 → done at cycle 1, div_by_zero=1, hi=0x12345678, lo=0xFFFFFFFF.
- DIV, 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0, div_by_zero=0.
- Complete a DIV (hi=5, lo=7), then start a DIVU and assert annul at cycle 10 → busy=0 at cycle 11, no done, hi/lo stay 5/7; a new start at cycle 12 completes normally.
- Assert rst at cycle 15 of a DIV → all outputs 0 next cycle. A start pulsed during CALC and a start pulsed during DONE are both ignored, with exactly one done pulse.
